hamming_dec_engine: RTL and testbench
=====================================

# hamming_dec_engine

Hardware SECDED decode engine for program 2. It walks the corrupted Hamming-encoded words in data memory at bytes 30–59 (two bytes per word). For each word it corrects a single-bit error or flags a double-bit error, then writes the 16-bit result to bytes 0–29. It sits beside the processor core on the data-memory port and raises `done` when all words are written, matching the program-2 completion handshake.

## Interface
- `NUM_WORDS`, default 15: number of encoded words to process.
- `SRC_BASE`, default 30: byte address of word 0 low byte. High byte is at `SRC_BASE+1`; word i is at `SRC_BASE+2i`.
- `DST_BASE`, default 0: byte address of result 0 low byte. Word i is at `DST_BASE+2i`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; returns the block to IDLE.
- `start`  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- `mem_rd_data`  in  8  read data; valid the cycle after `mem_addr` is presented.
- `mem_addr`  out  8  byte address for read or write.
- `mem_wr_en`  out  1  write strobe for `mem_wr_data` at `mem_addr`.
- `mem_wr_data`  out  8  write data.
- `busy`  out  1  high from the cycle after `start` until `done` rises.
- `done`  out  1  high when all words are written; held until the next accepted `start` or `reset`.
- `single_cnt`  out  4  number of words with a corrected single error in this run.
- `double_cnt`  out  4  number of words flagged with a double error in this run.

## Operation
- Encoded word layout, w[15:0]:
  - {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
  - Bit k (1–15) is Hamming position k; bit 0 is overall parity.
- Syndrome s[3:0] = XOR of indices k (1..15) for which w[k]=1.
- Overall parity P = ^w[15:0].
- Decode rules:
  - s=0, P=0: no error. result = {5'b00000, d}.
  - P=1: single error. If s≠0, invert w[s]; if s=0, the error is p0 and data is unchanged. result = {5'b01000, d_corrected}. Increment `single_cnt`.
  - s≠0, P=0: double error. result = {5'b10000, d_raw} with no correction. Increment `double_cnt`.
- d is {w15,w14,w13,w12,w11,w10,w9,w7,w6,w5,w3}, which is d[11:1].
- Result write order: low byte result[7:0] to `DST_BASE+2i`, then high byte result[15:8] to `DST_BASE+2i+1`.
- FSM states and transitions:
  - IDLE: on `start`, go to RD_LO.
  - RD_LO: present `SRC_BASE+2i`; go to RD_HI.
  - RD_HI: capture low byte; present `SRC_BASE+2i+1`; go to CAP.
  - CAP: capture high byte; go to WR_LO.
  - WR_LO: write low byte; go to WR_HI.
  - WR_HI: write high byte. If i = `NUM_WORDS`−1, go to DONE; otherwise increment i and go to RD_LO.
  - DONE: on `start`, go to RD_LO.
- Decode is combinational from the captured word register. Results are not stored between words.
- `start` while busy is ignored.
- An accepted `start` clears i, `single_cnt`, `double_cnt` and `done`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `single_cnt`=0, `double_cnt`=0.
- Each word takes 5 cycles.
- If `start` is sampled at edge t:
  - First RD_LO is the cycle after t.
  - `done` rises at edge t+1+5·`NUM_WORDS` (t+76 by default).
  - `busy` falls on the same edge.
- `mem_wr_en` is high only in WR_LO and WR_HI, for exactly 2·`NUM_WORDS` pulses per run.
- No write is ever issued to the source region.
- Counters update on the WR_HI edge of the affected word.
- `reset` mid-run: on the next edge go to IDLE with all outputs at reset values. Writes already issued stay in memory; no further writes are issued.
- `reset` and `start` in the same cycle: `reset` wins.

## Test plan
- Word encoded 0x0000 → result 0x0000 written as byte 0=0x00, byte 1=0x00. `single_cnt`=0.
- Word encoded 0xFFFF (d=0x7FF) → result 0x07FF. Word 0xFDFF (bit 9 flipped) → result 0x47FF. `single_cnt` increments.
- Word 0x0001 (p0 flipped) → result 0x4000. Word 0x0020 (bit 5 flipped) → result 0x4000.
- Word 0x0003 (bits 0 and 1 flipped) → result 0x8000; `double_cnt`=1.
- Full run of 15 random words built with the program-2 flip rules (75% single, ~25% double, rare zero):
  - All 30 result bytes match the reference decode.
  - `done` is seen exactly 76 cycles after `start`.
  - `single_cnt`+`double_cnt` equals the injected error count.
- `reset` asserted during word 7 → outputs return to reset values next cycle and no further writes occur. A new `start` then completes a full 15-word run correctly.

Source files
------------

// File: rtl/hamming_dec_engine.sv
// SECDED decode engine: reads encoded 16-bit words from byte memory, corrects
// single-bit errors or flags double-bit errors, and writes the 16-bit results back.
module hamming_dec_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] mem_rd_data,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic       busy,
  output logic       done,
  output logic [3:0] single_cnt,
  output logic [3:0] double_cnt
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_CAP, S_WR_LO, S_WR_HI, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   word_q, word_d;
  logic [3:0]    single_cnt_q, single_cnt_d;
  logic [3:0]    double_cnt_q, double_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]  src_lo, dst_lo;
  logic [3:0]  syn;
  logic        par;
  logic [15:0] corr;
  logic [10:0] d_raw, d_cor;
  logic [15:0] result;
  logic        is_single, is_double;

  assign src_lo = 8'(SRC_BASE) + 8'({idx_q, 1'b0});
  assign dst_lo = 8'(DST_BASE) + 8'({idx_q, 1'b0});

  // Decode is purely combinational from the captured word.
  always_comb begin
    syn = 4'd0;
    for (int k = 1; k < 16; k++)
      if (word_q[k]) syn = syn ^ 4'(k);
    par  = ^word_q;
    corr = word_q;
    if (par && syn != 4'd0) corr[syn] = ~word_q[syn];
    d_raw = {word_q[15:9], word_q[7:5], word_q[3]};
    d_cor = {corr[15:9], corr[7:5], corr[3]};
    is_single = par;
    is_double = !par && (syn != 4'd0);
    if (is_single)      result = {5'b01000, d_cor};
    else if (is_double) result = {5'b10000, d_raw};
    else                result = {5'b00000, d_raw};
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    mem_addr     = 8'd0;
    mem_wr_en    = 1'b0;
    mem_wr_data  = 8'd0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RD_LO;
          idx_d        = '0;
          single_cnt_d = 4'd0;
          double_cnt_d = 4'd0;
          done_d       = 1'b0;
          busy_d       = 1'b1;
        end else if (state_q == S_DONE) begin
          // done/busy are registered one cycle behind the DONE state entry
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_RD_LO: begin
        mem_addr = src_lo;
        state_d  = S_RD_HI;
      end
      S_RD_HI: begin
        word_d[7:0] = mem_rd_data;
        mem_addr    = src_lo + 8'd1;
        state_d     = S_CAP;
      end
      S_CAP: begin
        word_d[15:8] = mem_rd_data;
        state_d      = S_WR_LO;
      end
      S_WR_LO: begin
        mem_addr    = dst_lo;
        mem_wr_en   = 1'b1;
        mem_wr_data = result[7:0];
        state_d     = S_WR_HI;
      end
      S_WR_HI: begin
        mem_addr    = dst_lo + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = result[15:8];
        if (is_single) single_cnt_d = single_cnt_q + 4'd1;
        if (is_double) double_cnt_d = double_cnt_q + 4'd1;
        if (idx_q == IW'(NUM_WORDS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RD_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      word_q       <= 16'd0;
      single_cnt_q <= 4'd0;
      double_cnt_q <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign single_cnt = single_cnt_q;
  assign double_cnt = double_cnt_q;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Directed bench for hamming_dec_engine: byte memory model, hand-decoded words,
// done timing, counters, mid-run reset and restart.
module tb_hamming_dec_engine;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] mem_rd_data, mem_addr, mem_wr_data;
  logic       mem_wr_en, busy, done;
  logic [3:0] single_cnt, double_cnt;

  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_addr, tb_data;
  int         wr_cnt, src_wr_cnt;
  int         n_chk, n_pass, n_fail;

  logic [15:0] enc [15] = '{16'h0000, 16'hFFFF, 16'hFDFF, 16'h0001, 16'h0020,
                            16'h0003, 16'h000F, 16'h0007, 16'h8007, 16'h8000,
                            16'h0F00, 16'h0B00, 16'h0D01, 16'hF000, 16'hF040};
  logic [15:0] exp_res [15] = '{16'h0000, 16'h07FF, 16'h47FF, 16'h4000, 16'h4000,
                                16'h8000, 16'h0001, 16'h4001, 16'h8400, 16'h4000,
                                16'h0070, 16'h4070, 16'h8060, 16'h0780, 16'h4780};

  hamming_dec_engine dut (
    .clk(clk), .reset(reset), .start(start), .mem_rd_data(mem_rd_data),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read byte memory; the bench loads it through a side port.
  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_cnt++;
      if (mem_addr >= 8'd30 && mem_addr <= 8'd59) src_wr_cnt++;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 15; i++) begin
      poke(8'(30 + 2 * i), enc[i][7:0]);
      poke(8'(31 + 2 * i), enc[i][15:8]);
      poke(8'(2 * i), 8'hAA);
      poke(8'(2 * i + 1), 8'hAA);
    end
  endtask

  // Pulse start; returns number of edges after the start edge until done is seen.
  task automatic run(input int stop_at, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done && cyc < 300 && cyc != stop_at) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (cyc == 10);  // ignored: engine is busy
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("%s_lo%0d", tag, i), 32'(mem[2 * i]), 32'(exp_res[i][7:0]));
      chk($sformatf("%s_hi%0d", tag, i), 32'(mem[2 * i + 1]), 32'(exp_res[i][15:8]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(mem_wr_data), 32'd0);
    chk({tag, "_single"}, 32'(single_cnt), 32'd0);
    chk({tag, "_double"}, 32'(double_cnt), 32'd0);
  endtask

  initial begin
    int cyc, w0;
    n_chk = 0; n_pass = 0; n_fail = 0;
    wr_cnt = 0; src_wr_cnt = 0;
    tb_we = 1'b0; tb_addr = 8'd0; tb_data = 8'd0;
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Run 1: full 15-word pass with a spurious start mid-run
    load_mem();
    wr_cnt = 0;
    run(-1, cyc);
    chk("done_latency", 32'(cyc), 32'd76);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("single_cnt", 32'(single_cnt), 32'd7);
    chk("double_cnt", 32'(double_cnt), 32'd3);
    chk("write_pulses", 32'(wr_cnt), 32'd30);
    check_results("run1");
    repeat (5) @(negedge clk);
    chk("done_held", 32'(done), 32'd1);

    // Run 2: reset while word 7 is in flight (CAP state)
    load_mem();
    wr_cnt = 0;
    run(37, cyc);
    chk("mid_single", 32'(single_cnt), 32'd3);
    chk("mid_double", 32'(double_cnt), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    w0 = wr_cnt;
    chk("writes_before_reset", 32'(w0), 32'd14);
    start = 1'b1;  // reset wins over start
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    chk("reset_beats_start", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("no_writes_after_reset", 32'(wr_cnt), 32'(w0));
    chk("word7_not_written", 32'(mem[14]), 32'hAA);
    chk("prev_words_written", 32'(mem[13]), 32'(exp_res[6][15:8]));

    // Run 3: fresh start after reset completes normally
    run(-1, cyc);
    chk("restart_latency", 32'(cyc), 32'd76);
    chk("restart_single", 32'(single_cnt), 32'd7);
    chk("restart_double", 32'(double_cnt), 32'd3);
    check_results("run3");
    chk("src_writes", 32'(src_wr_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
